// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared state type and default width for seq_divider
// Contents: DIV_DEFAULT_WIDTH operand width default, div_state_e FSM encoding.
package seq_divider_pkg;

    localparam int DIV_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/result bundle between a requester and seq_divider
// master: drives start, dividend, divisor; observes busy, done, quotient, remainder, div_by_zero.
// slave : the divider side of the same signals.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division step (module div_step)
// rem_in : partial remainder (WIDTH+1 bits)   bit_in : next dividend bit, MSB first
// divisor: divisor magnitude                  rem_out: updated partial remainder
// q_bit  : quotient bit produced by this step
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {2'b00, divisor});
        // Whenever the subtraction is taken, shifted < 2*divisor, so its top bit
        // is zero and the WIDTH+1-bit difference is exact.
        diff    = shifted[WIDTH:0] - {1'b0, divisor};
        rem_out = q_bit ? diff : shifted[WIDTH:0];
    end
endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, one quotient bit per clock
// Ports: clk, rst (async active-high), bus (seq_divider_if.slave: start/dividend/divisor in,
//        busy/done/quotient/remainder/div_by_zero out).
// Build option: SEQ_DIVIDER_SIGNED_EN selects two's-complement operands (magnitude divide + sign fix).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // work_q shifts dividend bits out at the MSB and quotient bits in at the LSB,
    // so after WIDTH steps it holds the raw quotient.
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] dsor_q, dsor_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_raw, r_raw, q_fin, r_fin, op_a, op_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .bit_in  (work_q[WIDTH-1]),
        .divisor (dsor_q),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    assign q_raw = {work_q[WIDTH-2:0], q_bit};
    assign r_raw = rem_next[WIDTH-1:0];

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic q_neg_q, q_neg_d, r_neg_q, r_neg_d;

    // The most-negative value maps to itself, which read unsigned is its true magnitude.
    assign op_a  = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign op_b  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    assign q_fin = q_neg_q ? -q_raw : q_raw;
    assign r_fin = r_neg_q ? -r_raw : r_raw;

    always_comb begin
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        if (accept) begin
            q_neg_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            r_neg_d = bus.dividend[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end
`else
    assign op_a  = bus.dividend;
    assign op_b  = bus.divisor;
    assign q_fin = q_raw;
    assign r_fin = r_raw;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        dsor_d      = dsor_q;
        rem_d       = rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        accept      = bus.start && (state_q != RUN);

        case (state_q)
            RUN: begin
                work_d = q_raw;
                rem_d  = rem_next;
                cnt_d  = cnt_q - CNT_W'(1);
                // Results are published only on entry to FINISH so they stay stable throughout RUN.
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = FINISH;
                    quotient_d  = q_fin;
                    remainder_d = r_fin;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = state_q;
        endcase

        if (accept) begin
            work_d = op_a;
            dsor_d = op_b;
            rem_d  = '0;
            cnt_d  = CNT_W'(WIDTH);
            dbz_d  = 1'b0;
            if (bus.divisor == '0) begin
                state_d     = FINISH;
                quotient_d  = '1;
                remainder_d = bus.dividend;
                dbz_d       = 1'b1;
            end else begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            dsor_q      <= '0;
            rem_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            dsor_q      <= dsor_d;
            rem_q       <= rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == FINISH);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider (WIDTH=4)
module tb_seq_divider;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           t0;
        int           lat;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];
    logic [W-1:0] last_q, last_r;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        int sa, sb_i;
        if (b == '0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            sa   = $signed(a);
            sb_i = $signed(b);
`else
            sa   = int'(a);
            sb_i = int'(b);
`endif
            q = W'(sa / sb_i);
            r = W'(sa % sb_i);
            z = 1'b0;
        end
    endfunction

    // Called at a negedge; presents start for exactly one rising edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        exp_t e;
        if (push) begin
            model(a, b, e.q, e.r, e.z);
            e.t0  = cyc;
            e.lat = (b == '0) ? 1 : W + 1;
            sb.push_back(e);
        end
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic wait_check(input string name);
        exp_t e;
        int   k;
        k = 0;
        while (bus.done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: done got %b want 1", name, bus.done);
            return;
        end
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected done: queue size got 0 want >0", name);
            return;
        end
        e = sb.pop_front();
        last_q = e.q;
        last_r = e.r;
        n_tests++;
        if (cyc - e.t0 !== e.lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc - e.t0, e.lat);
        end
        n_tests++;
        if (bus.quotient !== e.q) begin
            n_fail++;
            $display("FAIL %s quotient: got %0h want %0h", name, bus.quotient, e.q);
        end
        n_tests++;
        if (bus.remainder !== e.r) begin
            n_fail++;
            $display("FAIL %s remainder: got %0h want %0h", name, bus.remainder, e.r);
        end
        n_tests++;
        if (bus.div_by_zero !== e.z || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s dbz/busy: got %b/%b want %b/0", name, bus.div_by_zero, bus.busy, e.z);
        end
    endtask

    task automatic test_reset();
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %b want 0",
                     {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle busy/done: got %b want 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_basic();
        launch(4'd13, 4'd3, 1'b1);
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic busy_in_run: got %b want 1", bus.busy);
        end
        wait_check("basic_13_3");
`ifndef SEQ_DIVIDER_SIGNED_EN
        n_tests++;
        if ({bus.quotient, bus.remainder} !== {4'd4, 4'd1}) begin
            n_fail++;
            $display("FAIL basic_const: got %0d/%0d want 4/1", bus.quotient, bus.remainder);
        end
`endif
        @(negedge clk);
        launch(4'd2, 4'd5, 1'b1);
        wait_check("small_2_5");
        @(negedge clk);
        launch(4'd15, 4'd1, 1'b1);
        wait_check("max_15_1");
        @(negedge clk);
        launch(4'd15, 4'd15, 1'b1);
        wait_check("max_15_15");
    endtask

    task automatic test_div_zero();
        @(negedge clk);
        launch(4'd7, 4'd0, 1'b1);
        wait_check("dbz_7_0");
        n_tests++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {4'd15, 4'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL dbz_const: got %0d/%0d/%b want 15/7/1",
                     bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(negedge clk);
        n_tests++;
        if (bus.div_by_zero !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL dbz_hold: dbz/done got %b/%b want 1/0", bus.div_by_zero, bus.done);
        end
    endtask

    task automatic test_hold();
        launch(4'd13, 4'd3, 1'b1);
        wait_check("hold_first");
        @(negedge clk);
        n_tests++;
        if (bus.done !== 1'b0 || bus.quotient !== last_q) begin
            n_fail++;
            $display("FAIL hold_after_done: done/q got %b/%0h want 0/%0h", bus.done, bus.quotient, last_q);
        end
        launch(4'd2, 4'd5, 1'b1);
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b1 || bus.quotient !== last_q || bus.remainder !== last_r) begin
            n_fail++;
            $display("FAIL hold_in_run: busy/q/r got %b/%0h/%0h want 1/%0h/%0h",
                     bus.busy, bus.quotient, bus.remainder, last_q, last_r);
        end
        wait_check("hold_second");
    endtask

    task automatic test_ignore_start();
        int dones;
        @(negedge clk);
        launch(4'd13, 4'd3, 1'b1);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 4'd9;
        bus.divisor  = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        wait_check("ignore_13_3");
        dones = 0;
        repeat (7) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        n_tests++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL ignore_extra_done: got %0d want 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        launch(4'd13, 4'd3, 1'b1);
        wait_check("b2b_first");
        launch(4'd9, 4'd2, 1'b1);
        wait_check("b2b_second");
        launch(4'd5, 4'd0, 1'b1);
        wait_check("b2b_dbz");
        launch(4'd14, 4'd4, 1'b1);
        wait_check("b2b_after_dbz");
    endtask

    task automatic test_reset_mid_run();
        int dones;
        @(negedge clk);
        launch(4'd13, 4'd3, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got %b want 0",
                     {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        n_tests++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL reset_no_done: got %0d want 0", dones);
        end
        launch(4'd11, 4'd4, 1'b1);
        wait_check("first_after_reset");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(0, 15));
            if (i % 2 == 0) @(negedge clk);
            launch(a, b, 1'b1);
            wait_check("random");
        end
    endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
    task automatic test_signed();
        @(negedge clk);
        launch(4'b1001, 4'd2, 1'b1);
        wait_check("signed_m7_2");
        n_tests++;
        if ({bus.quotient, bus.remainder} !== {4'b1101, 4'b1111}) begin
            n_fail++;
            $display("FAIL signed_m7_2_const: got %b/%b want 1101/1111", bus.quotient, bus.remainder);
        end
        @(negedge clk);
        launch(4'b1000, 4'b1111, 1'b1);
        wait_check("signed_m8_m1");
        n_tests++;
        if ({bus.quotient, bus.remainder} !== {4'b1000, 4'b0000}) begin
            n_fail++;
            $display("FAIL signed_m8_m1_const: got %b/%b want 1000/0000", bus.quotient, bus.remainder);
        end
    endtask
`endif

    initial begin
        cyc     = 0;
        n_tests = 0;
        n_fail  = 0;
        last_q  = '0;
        last_r  = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_hold();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
`ifdef SEQ_DIVIDER_SIGNED_EN
        test_signed();
`endif
        n_tests++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
